execute_stage: RTL and testbench

Execute stage of the 5-stage pipelined processor. It sits between the D/X latch and the X/M latch:
- consumes decoded PC, instruction and operand values;
- applies bypass selection from the M and W stages;
- performs ALU, branch and jump resolution, and iterative multiply/divide;
- registers results into the X/M latch.

It raises `stall` to freeze fetch/decode while a multi-cycle `mul`/`div` is in flight, and `flush` plus `target` on a taken control transfer.

---
 rtl/isa_pkg.sv | 58 +++++
 rtl/execute_stage_if.sv | 35 +++
 rtl/multdiv_iter.sv | 101 ++++++++++
 rtl/execute_stage.sv | 162 ++++++++++++++++
 tb/tb_execute_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the execute stage: opcodes, ALU ops, status codes,
// special register indices, multdiv FSM types and the operand bypass helper.
package isa_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [31:0] RSTAT_ADD  = 32'd1;
    localparam logic [31:0] RSTAT_ADDI = 32'd2;
    localparam logic [31:0] RSTAT_SUB  = 32'd3;
    localparam logic [31:0] RSTAT_MUL  = 32'd4;
    localparam logic [31:0] RSTAT_DIV  = 32'd5;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_RA     = 5'd31;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
    typedef enum logic {MD_MUL = 1'b0, MD_DIV = 1'b1} md_op_t;

    // M has priority over W; r0 is hardwired and never forwarded.
    function automatic logic [31:0] bypass(
        input logic [4:0]  src,
        input logic [31:0] dx_val,
        input logic        xm_we,
        input logic [4:0]  xm_rd,
        input logic [31:0] xm_o,
        input logic        mw_we,
        input logic [4:0]  mw_rd,
        input logic [31:0] mw_data
    );
        if (src != REG_ZERO && xm_we && xm_rd == src)
            return xm_o;
        else if (src != REG_ZERO && mw_we && mw_rd == src)
            return mw_data;
        else
            return dx_val;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// D/X inputs, M/W feedback and X/M latch outputs of the execute stage.
// master = surrounding pipeline, slave = execute stage.
interface execute_stage_if;
    logic [31:0] dx_pc;
    logic [31:0] dx_insn;
    logic [31:0] dx_a;
    logic [31:0] dx_b;
    logic        xm_we_fb;
    logic [4:0]  xm_rd_fb;
    logic [31:0] xm_o_fb;
    logic        mw_we;
    logic [4:0]  mw_rd;
    logic [31:0] mw_data;
    logic [31:0] xm_pc;
    logic [31:0] xm_insn;
    logic [31:0] xm_o;
    logic [31:0] xm_b;
    logic        xm_we;
    logic [4:0]  xm_rd;
    logic        stall;
    logic        flush;
    logic [31:0] target;

    modport master (
        output dx_pc, dx_insn, dx_a, dx_b,
        output xm_we_fb, xm_rd_fb, xm_o_fb, mw_we, mw_rd, mw_data,
        input  xm_pc, xm_insn, xm_o, xm_b, xm_we, xm_rd, stall, flush, target
    );

    modport slave (
        input  dx_pc, dx_insn, dx_a, dx_b,
        input  xm_we_fb, xm_rd_fb, xm_o_fb, mw_we, mw_rd, mw_data,
        output xm_pc, xm_insn, xm_o, xm_b, xm_we, xm_rd, stall, flush, target
    );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (shift-add) and divide (restoring) on operand
// magnitudes, one step per BUSY cycle; sign is applied to the final result.
//   state   | meaning
//   MD_IDLE | waiting for start; latches operand magnitudes
//   MD_BUSY | one iteration per cycle, MD_CYCLES cycles
//   MD_DONE | result/exception valid for one cycle (ready)
module multdiv_iter
    import isa_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  md_op_t      op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] result,
    output logic        exception,
    output logic        ready,
    output logic        busy
);

    localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

    md_state_t        state;
    logic [CNT_W-1:0] count;
    md_op_t           op_q;
    logic             neg_q;
    logic             div0_q;
    logic [63:0]      acc_q;   // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [31:0]      opr_q;   // mul: multiplicand magnitude; div: divisor magnitude

    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [63:0] div_next;

    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opr_q} : 33'd0);
    assign mul_next  = {mul_sum, acc_q[31:1]};
    assign rem_shift = {acc_q[63:32], acc_q[31]};
    assign rem_ge    = rem_shift >= {1'b0, opr_q};
    assign rem_sub   = rem_shift[31:0] - opr_q;
    assign div_next  = rem_ge ? {rem_sub, acc_q[30:0], 1'b1}
                              : {rem_shift[31:0], acc_q[30:0], 1'b0};

    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic        mul_ovf;

    assign prod_s  = neg_q ? (~acc_q + 64'd1) : acc_q;
    assign quo_s   = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign mul_ovf = (prod_s[63:31] != '0) && (prod_s[63:31] != '1);

    assign result    = (op_q == MD_MUL) ? prod_s[31:0] : (div0_q ? 32'd0 : quo_s);
    assign exception = (op_q == MD_MUL) ? mul_ovf : div0_q;
    assign ready     = (state == MD_DONE);
    assign busy      = (state == MD_BUSY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= MD_IDLE;
            count  <= '0;
            op_q   <= MD_MUL;
            neg_q  <= 1'b0;
            div0_q <= 1'b0;
            acc_q  <= '0;
            opr_q  <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        neg_q  <= operand_a[31] ^ operand_b[31];
                        div0_q <= (operand_b == 32'd0);
                        opr_q  <= (op == MD_MUL) ? mag(operand_a) : mag(operand_b);
                        acc_q  <= (op == MD_MUL) ? {32'd0, mag(operand_b)}
                                                 : {32'd0, mag(operand_a)};
                        count  <= '0;
                        state  <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    acc_q <= (op_q == MD_MUL) ? mul_next : div_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(MD_CYCLES - 1))
                        state <= MD_DONE;
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: bypass, ALU, branch/jump resolution and multdiv sequencing,
// registering results into the X/M latch.
module execute_stage
    import isa_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input logic            clock,
    input logic            reset,
    execute_stage_if.slave xif
);

    logic [4:0]  opcode, rd_f, rs_f, rt_f, shamt, aluop;
    logic [31:0] imm, jt;

    assign opcode = xif.dx_insn[31:27];
    assign rd_f   = xif.dx_insn[26:22];
    assign rs_f   = xif.dx_insn[21:17];
    assign rt_f   = xif.dx_insn[16:12];
    assign shamt  = xif.dx_insn[11:7];
    assign aluop  = xif.dx_insn[6:2];
    assign imm    = {{15{xif.dx_insn[16]}}, xif.dx_insn[16:0]};
    assign jt     = {5'd0, xif.dx_insn[26:0]};

    logic is_bne, is_blt, is_jr, is_bex, is_sw, is_md;
    assign is_bne = (opcode == OP_BNE);
    assign is_blt = (opcode == OP_BLT);
    assign is_jr  = (opcode == OP_JR);
    assign is_bex = (opcode == OP_BEX);
    assign is_sw  = (opcode == OP_SW);
    assign is_md  = (opcode == OP_RTYPE) && (aluop == ALU_MUL || aluop == ALU_DIV);

    // Branches compare $rd with $rs; sw carries its store data in $rd.
    logic [4:0]  a_src, b_src;
    logic [31:0] a_val, b_val;
    assign a_src = (is_bne || is_blt || is_jr) ? rd_f : rs_f;
    assign b_src = (is_bne || is_blt) ? rs_f :
                   is_bex             ? REG_STATUS :
                   is_sw              ? rd_f : rt_f;
    assign a_val = bypass(a_src, xif.dx_a, xif.xm_we_fb, xif.xm_rd_fb, xif.xm_o_fb,
                          xif.mw_we, xif.mw_rd, xif.mw_data);
    assign b_val = bypass(b_src, xif.dx_b, xif.xm_we_fb, xif.xm_rd_fb, xif.xm_o_fb,
                          xif.mw_we, xif.mw_rd, xif.mw_data);

    md_op_t      md_op;
    logic        md_start, md_busy, md_ready, md_exc;
    logic [31:0] md_result;

    assign md_op     = (aluop == ALU_DIV) ? MD_DIV : MD_MUL;
    assign md_start  = is_md && !md_busy && !md_ready;
    assign xif.stall = reset && (md_start || md_busy);

    multdiv_iter #(.MD_CYCLES(MD_CYCLES)) u_multdiv (
        .clock     (clock),
        .reset     (reset),
        .start     (md_start),
        .op        (md_op),
        .operand_a (a_val),
        .operand_b (b_val),
        .result    (md_result),
        .exception (md_exc),
        .ready     (md_ready),
        .busy      (md_busy)
    );

    logic [31:0] sum_ab, diff_ab, sum_imm;
    logic        ovf_add, ovf_sub, ovf_addi;
    assign sum_ab   = a_val + b_val;
    assign diff_ab  = a_val - b_val;
    assign sum_imm  = a_val + imm;
    assign ovf_add  = (a_val[31] == b_val[31]) && (sum_ab[31] != a_val[31]);
    assign ovf_sub  = (a_val[31] != b_val[31]) && (diff_ab[31] != a_val[31]);
    assign ovf_addi = (a_val[31] == imm[31]) && (sum_imm[31] != a_val[31]);

    logic [31:0] res, code;
    logic [4:0]  dest;
    logic        wr_en, exc;

    always_comb begin
        res   = '0;
        code  = '0;
        dest  = rd_f;
        wr_en = 1'b0;
        exc   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                wr_en = 1'b1;
                case (aluop)
                    ALU_ADD: begin res = sum_ab;  exc = ovf_add; code = RSTAT_ADD; end
                    ALU_SUB: begin res = diff_ab; exc = ovf_sub; code = RSTAT_SUB; end
                    ALU_AND: res = a_val & b_val;
                    ALU_OR:  res = a_val | b_val;
                    ALU_SLL: res = a_val << shamt;
                    ALU_SRA: res = $signed(a_val) >>> shamt;
                    ALU_MUL: begin res = md_result; exc = md_exc; code = RSTAT_MUL; end
                    ALU_DIV: begin res = md_result; exc = md_exc; code = RSTAT_DIV; end
                    default: wr_en = 1'b0;
                endcase
            end
            OP_ADDI: begin res = sum_imm; exc = ovf_addi; code = RSTAT_ADDI; wr_en = 1'b1; end
            OP_LW:   begin res = sum_imm; wr_en = 1'b1; end
            OP_SW:   res = sum_imm;
            OP_JAL:  begin res = xif.dx_pc; dest = REG_RA; wr_en = 1'b1; end
            OP_SETX: begin res = jt; dest = REG_STATUS; wr_en = 1'b1; end
            default: ;
        endcase
        if (exc) begin
            res  = code;
            dest = REG_STATUS;
        end
        // The all-zero nop must not look like a write to r0 downstream.
        if (xif.dx_insn == '0)
            wr_en = 1'b0;
        if (!wr_en)
            dest = '0;
    end

    logic        taken;
    logic [31:0] br_tgt;

    always_comb begin
        taken  = 1'b0;
        br_tgt = '0;
        case (opcode)
            OP_J, OP_JAL: begin taken = 1'b1; br_tgt = jt; end
            OP_JR:        begin taken = 1'b1; br_tgt = a_val; end
            OP_BNE:       begin taken = (a_val != b_val); br_tgt = xif.dx_pc + imm; end
            OP_BLT:       begin taken = ($signed(a_val) < $signed(b_val)); br_tgt = xif.dx_pc + imm; end
            OP_BEX:       begin taken = (b_val != 32'd0); br_tgt = jt; end
            default: ;
        endcase
    end

    assign xif.flush  = reset && taken && !xif.stall;
    assign xif.target = (reset && taken) ? br_tgt : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xif.xm_pc   <= '0;
            xif.xm_insn <= '0;
            xif.xm_o    <= '0;
            xif.xm_b    <= '0;
            xif.xm_we   <= 1'b0;
            xif.xm_rd   <= '0;
        end else if (xif.stall) begin
            xif.xm_pc   <= '0;
            xif.xm_insn <= '0;
            xif.xm_o    <= '0;
            xif.xm_b    <= '0;
            xif.xm_we   <= 1'b0;
            xif.xm_rd   <= '0;
        end else begin
            xif.xm_pc   <= xif.dx_pc;
            xif.xm_insn <= xif.dx_insn;
            xif.xm_o    <= res;
            xif.xm_b    <= b_val;
            xif.xm_we   <= wr_en;
            xif.xm_rd   <= dest;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expected X/M
// contents; a negedge monitor pops and compares every non-bubble X/M entry.
module tb_execute_stage;
    import isa_pkg::*;

    logic clock;
    logic reset;

    execute_stage_if xif();

    execute_stage #(.MD_CYCLES(32)) dut (
        .clock (clock),
        .reset (reset),
        .xif   (xif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] o;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    logic        p_xwe = 1'b0;
    logic [4:0]  p_xrd = '0;
    logic [31:0] p_xo  = '0;
    logic        p_mwe = 1'b0;
    logic [4:0]  p_mrd = '0;
    logic [31:0] p_md  = '0;

    function automatic logic [31:0] r_ins(input logic [4:0] alu, rd, rs, rt, sh);
        return {OP_RTYPE, rd, rs, rt, sh, alu, 2'b00};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] op, rd, rs, input logic [16:0] im);
        return {op, rd, rs, im};
    endfunction

    function automatic logic [31:0] j_ins(input logic [4:0] op, input logic [26:0] t);
        return {op, t};
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, insn, o, b, input logic [4:0] rd, input logic we);
        exp_t e;
        e.pc = pc; e.insn = insn; e.o = o; e.b = b; e.rd = rd; e.we = we;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_fb(input logic xwe, input logic [4:0] xrd, input logic [31:0] xo,
                          input logic mwe, input logic [4:0] mrd, input logic [31:0] md);
        p_xwe = xwe; p_xrd = xrd; p_xo = xo;
        p_mwe = mwe; p_mrd = mrd; p_md = md;
    endtask

    task automatic apply_fb();
        xif.xm_we_fb = p_xwe; xif.xm_rd_fb = p_xrd; xif.xm_o_fb = p_xo;
        xif.mw_we    = p_mwe; xif.mw_rd    = p_mrd; xif.mw_data = p_md;
        set_fb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic drive(input logic [31:0] pc, insn, a, b);
        xif.dx_pc = pc; xif.dx_insn = insn; xif.dx_a = a; xif.dx_b = b;
        apply_fb();
    endtask

    // One-cycle instruction in X; flush/target are combinational so checked here.
    task automatic issue(input logic [31:0] pc, insn, a, b, input exp_t e,
                         input bit chk_fl, input bit exp_fl,
                         input bit chk_tg, input logic [31:0] exp_tg);
        @(posedge clock); #1;
        drive(pc, insn, a, b);
        exp_q.push_back(e);
        #1;
        check("stall_single_cycle", {31'd0, xif.stall}, 32'd0);
        if (chk_fl) check("flush", {31'd0, xif.flush}, {31'd0, exp_fl});
        if (chk_tg) check("target", xif.target, exp_tg);
    endtask

    task automatic run_md(input logic [31:0] pc, insn, a, b, input exp_t e);
        int n;
        n = 0;
        @(posedge clock); #1;
        drive(pc, insn, a, b);
        exp_q.push_back(e);
        #1;
        while (xif.stall && n < 100) begin
            n++;
            if (n == 2) check("stall_bubble", {xif.xm_insn[30:0], xif.xm_we}, 32'd0);
            @(posedge clock); #2;
        end
        check("stall_cycles", n, 32'd33);
        check("flush_md_done", {31'd0, xif.flush}, 32'd0);
        @(posedge clock); #1;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    always @(negedge clock) begin
        if (xif.xm_insn != 32'd0) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL xm_unexpected: got insn=%h o=%h, expected no entry", xif.xm_insn, xif.xm_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (xif.xm_pc !== e.pc || xif.xm_insn !== e.insn || xif.xm_o !== e.o ||
                    xif.xm_b !== e.b || xif.xm_rd !== e.rd || xif.xm_we !== e.we) begin
                    fails++;
                    $display("FAIL xm_latch: got pc=%h insn=%h o=%h b=%h rd=%0d we=%b, expected pc=%h insn=%h o=%h b=%h rd=%0d we=%b",
                             xif.xm_pc, xif.xm_insn, xif.xm_o, xif.xm_b, xif.xm_rd, xif.xm_we,
                             e.pc, e.insn, e.o, e.b, e.rd, e.we);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ins;
        reset = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        #12;
        check("rst_xm_pc",   xif.xm_pc, 32'd0);
        check("rst_xm_insn", xif.xm_insn, 32'd0);
        check("rst_xm_o",    xif.xm_o, 32'd0);
        check("rst_xm_b",    xif.xm_b, 32'd0);
        check("rst_xm_we",   {31'd0, xif.xm_we}, 32'd0);
        check("rst_xm_rd",   {27'd0, xif.xm_rd}, 32'd0);
        check("rst_stall",   {31'd0, xif.stall}, 32'd0);
        check("rst_flush",   {31'd0, xif.flush}, 32'd0);
        check("rst_target",  xif.target, 32'd0);
        #1 reset = 1'b1;

        // Back-to-back add with M bypass, W bypass, M-over-W priority, r0 not forwarded.
        ins = r_ins(ALU_ADD, 5'd1, 5'd3, 5'd0, 5'd0);
        issue(32'h100, ins, 32'd5, 32'd0, mk(32'h100, ins, 32'd5, 32'd0, 5'd1, 1'b1), 0, 0, 0, 0);
        set_fb(1'b1, 5'd1, 32'd5, 1'b0, 5'd0, 32'd0);
        ins = r_ins(ALU_ADD, 5'd2, 5'd1, 5'd1, 5'd0);
        issue(32'h101, ins, 32'd0, 32'd0, mk(32'h101, ins, 32'd10, 32'd5, 5'd2, 1'b1), 1, 0, 0, 0);
        set_fb(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'd3);
        ins = r_ins(ALU_SUB, 5'd4, 5'd5, 5'd6, 5'd0);
        issue(32'h102, ins, 32'd20, 32'd99, mk(32'h102, ins, 32'd17, 32'd3, 5'd4, 1'b1), 0, 0, 0, 0);
        set_fb(1'b1, 5'd7, 32'd100, 1'b1, 5'd7, 32'd200);
        ins = r_ins(ALU_ADD, 5'd9, 5'd7, 5'd8, 5'd0);
        issue(32'h103, ins, 32'd1, 32'd2, mk(32'h103, ins, 32'd102, 32'd2, 5'd9, 1'b1), 0, 0, 0, 0);
        set_fb(1'b1, 5'd0, 32'd123, 1'b1, 5'd0, 32'd77);
        ins = r_ins(ALU_ADD, 5'd10, 5'd0, 5'd0, 5'd0);
        issue(32'h104, ins, 32'd0, 32'd0, mk(32'h104, ins, 32'd0, 32'd0, 5'd10, 1'b1), 0, 0, 0, 0);

        // Overflow exceptions redirect to r30 with status codes.
        ins = i_ins(OP_ADDI, 5'd5, 5'd3, 17'd1);
        issue(32'h105, ins, 32'h7FFFFFFF, 32'd0, mk(32'h105, ins, 32'd2, 32'd0, 5'd30, 1'b1), 0, 0, 0, 0);
        ins = r_ins(ALU_ADD, 5'd11, 5'd1, 5'd2, 5'd0);
        issue(32'h106, ins, 32'h7FFFFFFF, 32'd1, mk(32'h106, ins, 32'd1, 32'd1, 5'd30, 1'b1), 0, 0, 0, 0);
        ins = r_ins(ALU_SUB, 5'd12, 5'd1, 5'd2, 5'd0);
        issue(32'h107, ins, 32'h80000000, 32'd1, mk(32'h107, ins, 32'd3, 32'd1, 5'd30, 1'b1), 0, 0, 0, 0);

        // Logic and shifts.
        ins = r_ins(ALU_AND, 5'd13, 5'd1, 5'd2, 5'd0);
        issue(32'h108, ins, 32'h0000F0F0, 32'h0000FF00, mk(32'h108, ins, 32'h0000F000, 32'h0000FF00, 5'd13, 1'b1), 0, 0, 0, 0);
        ins = r_ins(ALU_SRA, 5'd14, 5'd1, 5'd0, 5'd4);
        issue(32'h109, ins, 32'h80000000, 32'd0, mk(32'h109, ins, 32'hF8000000, 32'd0, 5'd14, 1'b1), 0, 0, 0, 0);
        ins = r_ins(ALU_SLL, 5'd15, 5'd1, 5'd0, 5'd4);
        issue(32'h10A, ins, 32'd1, 32'd0, mk(32'h10A, ins, 32'h10, 32'd0, 5'd15, 1'b1), 0, 0, 0, 0);

        // Control transfers.
        ins = i_ins(OP_BNE, 5'd1, 5'd2, 17'h1FFFE);
        issue(32'h10, ins, 32'd3, 32'd4, mk(32'h10, ins, 32'd0, 32'd4, 5'd0, 1'b0), 1, 1, 1, 32'h0E);
        ins = i_ins(OP_BNE, 5'd1, 5'd2, 17'h1FFFE);
        issue(32'h20, ins, 32'd5, 32'd5, mk(32'h20, ins, 32'd0, 32'd5, 5'd0, 1'b0), 1, 0, 0, 0);
        ins = i_ins(OP_BLT, 5'd1, 5'd2, 17'd4);
        issue(32'h30, ins, 32'hFFFFFFFB, 32'd2, mk(32'h30, ins, 32'd0, 32'd2, 5'd0, 1'b0), 1, 1, 1, 32'h34);
        ins = j_ins(OP_JAL, 27'h123);
        issue(32'h40, ins, 32'd0, 32'd0, mk(32'h40, ins, 32'h40, 32'd0, 5'd31, 1'b1), 1, 1, 1, 32'h123);
        set_fb(1'b1, 5'd4, 32'd55, 1'b0, 5'd0, 32'd0);
        ins = i_ins(OP_SW, 5'd4, 5'd3, 17'd8);
        issue(32'h41, ins, 32'd100, 32'd77, mk(32'h41, ins, 32'd108, 32'd55, 5'd0, 1'b0), 1, 0, 0, 0);
        ins = j_ins(OP_SETX, 27'h55);
        issue(32'h42, ins, 32'd0, 32'd0, mk(32'h42, ins, 32'h55, 32'd0, 5'd30, 1'b1), 1, 0, 0, 0);

        // Multdiv.
        ins = r_ins(ALU_MUL, 5'd8, 5'd1, 5'd2, 5'd0);
        run_md(32'h50, ins, 32'hFFFFFFF9, 32'd6, mk(32'h50, ins, 32'hFFFFFFD6, 32'd6, 5'd8, 1'b1));
        ins = r_ins(ALU_DIV, 5'd9, 5'd1, 5'd2, 5'd0);
        run_md(32'h51, ins, 32'd10, 32'd0, mk(32'h51, ins, 32'd5, 32'd0, 5'd30, 1'b1));
        run_md(32'h52, ins, 32'hFFFFFF9C, 32'd7, mk(32'h52, ins, 32'hFFFFFFF2, 32'd7, 5'd9, 1'b1));
        ins = r_ins(ALU_MUL, 5'd8, 5'd1, 5'd2, 5'd0);
        run_md(32'h53, ins, 32'h00010000, 32'h00010000, mk(32'h53, ins, 32'd4, 32'h00010000, 5'd30, 1'b1));

        // Reset pulse in BUSY cycle 10 aborts the op; the next mul runs normally.
        @(posedge clock); #1;
        drive(32'h60, ins, 32'd9, 32'd9);
        repeat (11) @(posedge clock);
        #1;
        reset = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        #1;
        check("reset_abort_stall", {31'd0, xif.stall}, 32'd0);
        check("reset_abort_xm_we", {31'd0, xif.xm_we}, 32'd0);
        #2 reset = 1'b1;
        run_md(32'h61, ins, 32'd100, 32'hFFFFFFFD, mk(32'h61, ins, 32'hFFFFFED4, 32'hFFFFFFFD, 5'd8, 1'b1));

        @(posedge clock); #1;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
